// File: rtl/regfile_sb_if.sv
// Register file bus: decode read/reserve ports, writeback port, clear/ready.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            clear;
    logic            ready;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;

    modport master (
        output clear, ra1, ra2, we, wa, wd, rsv_en, rsv_addr,
        input  ready, rd1, rd2, busy1, busy2
    );

    modport slave (
        input  clear, ra1, ra2, we, wa, wd, rsv_en, rsv_addr,
        output ready, rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with clear sweep and busy scoreboard.
// Optional write-through forwarding under macro REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [XLEN-1:0] r_mem [NREGS];

    logic            w_run;
    logic            w_wr_ok;
    logic            w_rsv_ok;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_wa;
    logic [XLEN-1:0] w_mem_wd;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_busy1;
    logic            w_busy2;

    assign w_run    = (r_state == S_RUN);
    assign w_wr_ok  = bus.we && !(ZERO_REG != 0 && bus.wa == '0);
    assign w_rsv_ok = bus.rsv_en && !(ZERO_REG != 0 && bus.rsv_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_mem_we    = 1'b0;
        w_mem_wa    = bus.wa;
        w_mem_wd    = bus.wd;
        unique case (r_state)
            S_INIT: begin
                w_busy_nxt = '0;
                if (bus.clear) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_mem_we  = 1'b1;
                    w_mem_wa  = r_cnt;
                    w_mem_wd  = '0;
                    w_cnt_nxt = r_cnt + AW'(1);
                    if (r_cnt == AW'(NREGS - 1))
                        w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.clear) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = '0;
                end else begin
                    w_mem_we = w_wr_ok;
                    // Reservation applied last so a new producer wins.
                    if (w_wr_ok)
                        w_busy_nxt[bus.wa] = 1'b0;
                    if (w_rsv_ok)
                        w_busy_nxt[bus.rsv_addr] = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_wa] <= w_mem_wd;
    end

    always_comb begin
        w_rd1   = '0;
        w_rd2   = '0;
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        if (w_run) begin
            if (!(ZERO_REG != 0 && bus.ra1 == '0))
                w_rd1 = r_mem[bus.ra1];
            if (!(ZERO_REG != 0 && bus.ra2 == '0))
                w_rd2 = r_mem[bus.ra2];
            w_busy1 = r_busy[bus.ra1];
            w_busy2 = r_busy[bus.ra2];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && bus.wa == bus.ra1) begin
                w_rd1   = bus.wd;
                w_busy1 = w_rsv_ok && bus.rsv_addr == bus.ra1;
            end
            if (w_wr_ok && bus.wa == bus.ra2) begin
                w_rd2   = bus.wd;
                w_busy2 = w_rsv_ok && bus.rsv_addr == bus.ra2;
            end
`endif
        end
    end

    assign bus.ready = w_run;
    assign bus.rd1   = w_rd1;
    assign bus.rd2   = w_rd2;
    assign bus.busy1 = w_busy1;
    assign bus.busy2 = w_busy2;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep, read/write, scoreboard, clear, reset.
module tb_regfile_sb;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    regfile_sb_if #(.XLEN(32), .NREGS(32)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.clear    = 1'b0;
        bus.we       = 1'b0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
    endtask

    // Expects ready low after edges 1..31 and high after edge 32.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            total++;
            if (bus.ready !== (i == 32)) begin
                bad++;
                $display("FAIL %s edge=%0d ready=%b exp=%b",
                         tag, i, bus.ready, (i == 32));
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        idle_inputs();
        bus.ra1 = 5'd5;
        bus.ra2 = 5'd0;
        repeat (2) cyc();
        #1;
        total++;
        if (bus.ready !== 1'b0 || bus.rd1 !== 32'h0 || bus.busy1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state ready=%b rd1=%h busy1=%b exp 0/0/0",
                     bus.ready, bus.rd1, bus.busy1);
        end
        cyc();
        rst_n = 1'b1;
        sweep_check("reset_sweep");
        #1;
        total++;
        if (bus.rd1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd1 got=%h exp=0", bus.rd1);
        end
    endtask

    task automatic test_write_read();
        cyc();
        bus.we  = 1'b1;
        bus.wa  = 5'd3;
        bus.wd  = 32'hDEADBEEF;
        bus.ra1 = 5'd3;
        bus.ra2 = 5'd3;
        cyc();
        bus.we = 1'b0;
        #1;
        total++;
        if (bus.rd1 !== 32'hDEADBEEF || bus.rd2 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_rd12 rd1=%h rd2=%h exp=deadbeef",
                     bus.rd1, bus.rd2);
        end
        bus.we  = 1'b1;
        bus.wa  = 5'd0;
        bus.wd  = 32'h1234;
        bus.ra1 = 5'd0;
        cyc();
        bus.we = 1'b0;
        #1;
        total++;
        if (bus.rd1 !== 32'h0) begin
            bad++;
            $display("FAIL zero_reg got=%h exp=0", bus.rd1);
        end
    endtask

    task automatic test_scoreboard();
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd7;
        bus.ra1      = 5'd7;
        #1;
        total++;
        if (bus.busy1 !== 1'b0) begin
            bad++;
            $display("FAIL rsv_nobypass busy1=%b exp=0", bus.busy1);
        end
        cyc();
        bus.rsv_en = 1'b0;
        #1;
        total++;
        if (bus.busy1 !== 1'b1) begin
            bad++;
            $display("FAIL rsv_set busy1=%b exp=1", bus.busy1);
        end
        bus.we = 1'b1;
        bus.wa = 5'd7;
        bus.wd = 32'h55;
        #1;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (bus.busy1 !== 1'b0 || bus.rd1 !== 32'h55) begin
`else
        if (bus.busy1 !== 1'b1 || bus.rd1 !== 32'h0) begin
`endif
            bad++;
            $display("FAIL wb_same_cycle busy1=%b rd1=%h",
                     bus.busy1, bus.rd1);
        end
        cyc();
        bus.we = 1'b0;
        #1;
        total++;
        if (bus.busy1 !== 1'b0 || bus.rd1 !== 32'h55) begin
            bad++;
            $display("FAIL wb_clear busy1=%b rd1=%h exp 0/55",
                     bus.busy1, bus.rd1);
        end
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd9;
        bus.we       = 1'b1;
        bus.wa       = 5'd9;
        bus.wd       = 32'h99;
        bus.ra2      = 5'd9;
        cyc();
        idle_inputs();
        #1;
        total++;
        if (bus.busy2 !== 1'b1 || bus.rd2 !== 32'h99) begin
            bad++;
            $display("FAIL set_wins busy2=%b rd2=%h exp 1/99",
                     bus.busy2, bus.rd2);
        end
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd0;
        bus.ra1      = 5'd0;
        cyc();
        bus.rsv_en = 1'b0;
        #1;
        total++;
        if (bus.busy1 !== 1'b0) begin
            bad++;
            $display("FAIL rsv_zero busy1=%b exp=0", bus.busy1);
        end
    endtask

    task automatic test_clear();
        bus.we  = 1'b1;
        bus.wa  = 5'd12;
        bus.wd  = 32'hA5A5A5A5;
        bus.ra1 = 5'd12;
        cyc();
        bus.we = 1'b0;
        #1;
        total++;
        if (bus.rd1 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL clr_pre rd1=%h exp=a5a5a5a5", bus.rd1);
        end
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        #1;
        total++;
        if (bus.ready !== 1'b0 || bus.rd1 !== 32'h0 || bus.busy2 !== 1'b0) begin
            bad++;
            $display("FAIL clr_init ready=%b rd1=%h busy2=%b exp 0/0/0",
                     bus.ready, bus.rd1, bus.busy2);
        end
        sweep_check("clear_sweep");
        #1;
        total++;
        if (bus.rd1 !== 32'h0 || bus.busy2 !== 1'b0) begin
            bad++;
            $display("FAIL clr_post rd1=%h busy2=%b exp 0/0",
                     bus.rd1, bus.busy2);
        end
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        repeat (10) cyc();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        sweep_check("clear_restart");
    endtask

    task automatic test_async_reset();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        repeat (20) cyc();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_sweep ready=%b exp=0", bus.ready);
        end
        #1 rst_n = 1'b1;
        sweep_check("rst_sweep1");
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd4;
        bus.ra1      = 5'd4;
        cyc();
        bus.rsv_en = 1'b0;
        #1;
        total++;
        if (bus.busy1 !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre busy1=%b exp=1", bus.busy1);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (bus.ready !== 1'b0 || bus.busy1 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_run ready=%b busy1=%b exp 0/0",
                     bus.ready, bus.busy1);
        end
        #1 rst_n = 1'b1;
        sweep_check("rst_sweep2");
        #1;
        total++;
        if (bus.busy1 !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_post busy1=%b exp=0", bus.busy1);
        end
    endtask

    task automatic test_bypass();
        bus.ra1 = 5'd6;
        bus.we  = 1'b1;
        bus.wa  = 5'd6;
        bus.wd  = 32'h77;
        #1;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (bus.rd1 !== 32'h77) begin
            bad++;
            $display("FAIL bypass_same rd1=%h exp=77", bus.rd1);
        end
`else
        if (bus.rd1 !== 32'h0) begin
            bad++;
            $display("FAIL bypass_same rd1=%h exp=0", bus.rd1);
        end
`endif
        cyc();
        bus.we = 1'b0;
        #1;
        total++;
        if (bus.rd1 !== 32'h77) begin
            bad++;
            $display("FAIL bypass_next rd1=%h exp=77", bus.rd1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_clear();
        test_async_reset();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Generalised in XLEN and register count; optional hardwired-zero register.
- Adds a sequential clear sweep, so storage needs no reset and maps to RAM.
- Adds a per-register busy scoreboard so the controller can detect RAW hazards.
- Sits between decode (read addresses, reservations) and writeback (write port) in the core datapath.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers (power of two, >= 2). Local AW = $clog2(NREGS).
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- clear  in  1  sync request: re-zero all registers and busy bits.
- ready  out  1  high when the sweep is done and the file is usable.
- ra1  in  AW  read address 1 (rs1).
- ra2  in  AW  read address 2 (rs2).
- rd1  out  XLEN  read data 1.
- rd2  out  XLEN  read data 2.
- busy1  out  1  scoreboard bit of ra1.
- busy2  out  1  scoreboard bit of ra2.
- we  in  1  write enable (RegWrite).
- wa  in  AW  write address (rd).
- wd  in  XLEN  write data (writeback result).
- rsv_en  in  1  mark register rsv_addr busy (issue of a producer).
- rsv_addr  in  AW  register to reserve.

Behaviour:
- Storage array has no reset. Busy vector, FSM state and sweep counter reset asynchronously on rst_n low.
- Reset values: state=INIT, cnt=0, busy=0, ready=0. rd1, rd2, busy1, busy2 are 0 throughout INIT.
- FSM INIT:
  - Each rising edge writes 0 to reg[cnt], then cnt++.
  - After the edge writing NREGS-1, go to RUN. ready rises on the NREGS-th edge after rst_n release.
  - we and rsv_en are ignored in INIT.
- FSM RUN:
  - ready=1.
  - clear=1 at an edge: go to INIT with cnt=0 and busy=0; ready drops the next cycle.
- clear during INIT restarts the sweep at cnt=0.
- rst_n low mid-sweep or mid-operation returns to INIT/cnt=0 immediately (async). Array contents are then undefined until the sweep rewrites them.
- Reads: combinational from ra1/ra2 in RUN. With ZERO_REG=1, address 0 reads 0.
- Writes: in RUN, we=1 writes wd to reg[wa] at the edge; visible on rd* in the following cycle. With ZERO_REG=1, writes to wa=0 are dropped.
- Scoreboard, in RUN at each edge:
  - we clears busy[wa].
  - rsv_en sets busy[rsv_addr].
  - Same address, both events: set wins (new producer supersedes).
  - rsv_addr=0 with ZERO_REG=1: ignored.
- busy1/busy2 are combinational from busy[ra1]/busy[ra2]; no bypass of same-cycle rsv_en or we.
- Both read ports may address the same register; both return identical data.
- NREGS=2 is legal; the sweep then takes 2 cycles.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: in RUN, if we=1, wa==raN and (ZERO_REG=0 or wa!=0), rdN = wd combinationally in the same cycle (write-through). busyN for that port reads 0 in that cycle unless rsv_en targets the same address.
- Undefined: no forwarding. rdN shows the old value until after the edge, and busyN shows the stored bit.

Test Plan:
- Release rst_n, clear=0 -> ready=0 for 32 edges, high from edge 32. rd1 with ra1=5 reads 0 after ready.
- RUN: we=1, wa=3, wd=0xDEADBEEF, then ra1=3, ra2=3 next cycle -> rd1=rd2=0xDEADBEEF. we=1, wa=0, wd=0x1234 -> rd1 at ra1=0 stays 0.
- rsv_en=1, rsv_addr=7 -> next cycle busy1=1 for ra1=7. Then we=1, wa=7, wd=0x55 -> busy1=0, rd1=0x55. Same-edge rsv_en and we on addr 9 -> busy=1 and data written.
- Write 0xA5A5A5A5 to reg 12, pulse clear -> ready=0 for 32 cycles. Then reg 12 reads 0 and all busy=0. Pulse clear at cnt=10 -> sweep restarts, ready only after 32 more edges.
- Assert rst_n low mid-sweep (cnt=20) and mid-RUN with busy[4]=1 -> ready=0 and busy=0 immediately, full 32-cycle sweep follows.
- Bypass: REGFILE_BYPASS_EN defined, we=1, wa=ra1=6, wd=0x77 -> rd1=0x77 in the same cycle. Undefined -> rd1 shows the old value, 0x77 next cycle.
